sound_latch_ctrl: RTL and testbench

// 68000 -> Z80 sound-command mailbox, downstream of the address decoder.
// - Captures the byte the 68000 writes while sound_latch_cs is decoded.
// - Presents that byte to the Z80 while z80_latch_cs is decoded (0xf800 read).
// - Drives the Z80 NMI line until the Z80 has consumed the command.
// - Counts commands overwritten before the Z80 read them, for debug.
//

---
 rtl/sound_latch_ctrl_pkg.sv | 8 +
 rtl/sound_latch_ctrl_if.sv | 30 +++
 rtl/sound_latch_ctrl.sv | 83 ++++++++
 tb/tb_sound_latch_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_latch_ctrl_pkg.sv
// Shared sound-subsystem constants for the 68000 -> Z80 command mailbox.
package sound_latch_ctrl_pkg;

  localparam int unsigned SND_NMI_MIN_CYCLES = 16;
  localparam int unsigned SND_LATCH_W        = 8;
  localparam int unsigned SND_OVR_W          = 8;

endpackage : sound_latch_ctrl_pkg

// File: rtl/sound_latch_ctrl_if.sv
// Decoded 68000 write side and Z80 read side of the sound-command mailbox.
interface sound_latch_ctrl_if
  import sound_latch_ctrl_pkg::*;
#(
  parameter int unsigned OVR_W = SND_OVR_W
);

  logic                   m68k_latch_cs;
  logic                   m68k_rw;
  logic                   m68k_lds_n;
  logic [SND_LATCH_W-1:0] m68k_din;
  logic                   z80_latch_cs;
  logic                   z80_rd_n;
  logic [SND_LATCH_W-1:0] z80_dout;
  logic                   z80_nmi_n;
  logic                   pending;
  logic [OVR_W-1:0]       overrun_cnt;

  // Address-decoder / CPU side drives strobes and data, observes the mailbox.
  modport master (
    output m68k_latch_cs, m68k_rw, m68k_lds_n, m68k_din, z80_latch_cs, z80_rd_n,
    input  z80_dout, z80_nmi_n, pending, overrun_cnt
  );

  modport slave (
    input  m68k_latch_cs, m68k_rw, m68k_lds_n, m68k_din, z80_latch_cs, z80_rd_n,
    output z80_dout, z80_nmi_n, pending, overrun_cnt
  );

endinterface : sound_latch_ctrl_if

// File: rtl/sound_latch_ctrl.sv
// 68000 -> Z80 sound-command latch with stretched NMI and overrun counter.
module sound_latch_ctrl
  import sound_latch_ctrl_pkg::*;
#(
  parameter int unsigned NMI_MIN_CYCLES = SND_NMI_MIN_CYCLES,
  parameter int unsigned OVR_W          = SND_OVR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  sound_latch_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(NMI_MIN_CYCLES + 1);

  logic                   wr_q, wr_d;
  logic                   rd_q, rd_d;
  logic [SND_LATCH_W-1:0] latch_q, latch_d;
  logic                   pending_q, pending_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [OVR_W-1:0]       ovr_q, ovr_d;
  logic                   nmi_n_q, nmi_n_d;

  logic accept, rd_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      latch_q   <= '0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      ovr_q     <= '0;
      nmi_n_q   <= 1'b1;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      latch_q   <= latch_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      ovr_q     <= ovr_d;
      nmi_n_q   <= nmi_n_d;
    end
  end

  // One accept per 68k bus cycle (rising edge of the write request);
  // a command is consumed on the falling edge of the Z80 read.
  always_comb begin
    wr_d      = bus.m68k_latch_cs & ~bus.m68k_rw & ~bus.m68k_lds_n;
    rd_d      = bus.z80_latch_cs & ~bus.z80_rd_n;
    accept    = wr_d & ~wr_q;
    rd_end    = ~rd_d & rd_q;

    latch_d   = latch_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    ovr_d     = ovr_q;

    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (accept) begin
      latch_d   = bus.m68k_din;
      pending_d = 1'b1;
      cnt_d     = CNT_W'(NMI_MIN_CYCLES);
    end else if (rd_end) begin
      pending_d = 1'b0;
    end

    // A read ending in the same cycle means the old command was consumed.
    if (accept && pending_q && !rd_end && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + OVR_W'(1);
    end

    nmi_n_d = ~(pending_d | (cnt_d != '0));
  end

  assign bus.z80_dout    = latch_q;
  assign bus.z80_nmi_n   = nmi_n_q;
  assign bus.pending     = pending_q;
  assign bus.overrun_cnt = ovr_q;

endmodule : sound_latch_ctrl

// File: tb/tb_sound_latch_ctrl.sv
// Scoreboard bench for the 68000 -> Z80 sound-command mailbox.
module tb_sound_latch_ctrl;
  import sound_latch_ctrl_pkg::*;

  localparam int unsigned OVR_W   = 8;
  localparam int unsigned OVR_MAX = (1 << OVR_W) - 1;

  localparam int SEL_DOUT = 0;
  localparam int SEL_NMI  = 1;
  localparam int SEL_PEND = 2;
  localparam int SEL_OVR  = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } sb_entry_t;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  sb_entry_t sb_q[$];

  sound_latch_ctrl_if #(.OVR_W(OVR_W)) bus ();

  sound_latch_ctrl #(
    .NMI_MIN_CYCLES(16),
    .OVR_W         (OVR_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_DOUT: return 32'(bus.z80_dout);
      SEL_NMI:  return 32'(bus.z80_nmi_n);
      SEL_PEND: return 32'(bus.pending);
      default:  return 32'(bus.overrun_cnt);
    endcase
  endfunction

  task automatic expect_o(input string tag, input int sel, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    sb_entry_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [7:0] dout, input logic nmi_n,
                            input logic pend, input logic [31:0] ovr);
    expect_o({tag, ".dout"}, SEL_DOUT, 32'(dout));
    expect_o({tag, ".nmi_n"}, SEL_NMI, 32'(nmi_n));
    expect_o({tag, ".pending"}, SEL_PEND, 32'(pend));
    expect_o({tag, ".ovr"}, SEL_OVR, ovr);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_start(input logic [7:0] d);
    bus.m68k_latch_cs = 1'b1;
    bus.m68k_rw       = 1'b0;
    bus.m68k_lds_n    = 1'b0;
    bus.m68k_din      = d;
  endtask

  task automatic wr_stop();
    bus.m68k_latch_cs = 1'b0;
    bus.m68k_rw       = 1'b1;
    bus.m68k_lds_n    = 1'b1;
  endtask

  task automatic rd_start();
    bus.z80_latch_cs = 1'b1;
    bus.z80_rd_n     = 1'b0;
  endtask

  task automatic rd_stop();
    bus.z80_latch_cs = 1'b0;
    bus.z80_rd_n     = 1'b1;
  endtask

  // Bounded wait; returns the number of ticks until NMI was seen high.
  task automatic wait_nmi_high(input int max_ticks, output int n);
    n = 0;
    for (int i = 0; i < max_ticks; i++) begin
      tick();
      n++;
      if (bus.z80_nmi_n === 1'b1) break;
    end
  endtask

  // Full Z80 read of the latch, ending with the read-end edge.
  task automatic z80_read();
    rd_start();
    tick();
    tick();
    rd_stop();
    tick();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.m68k_din = 8'h00;
    wr_stop();
    rd_stop();

    // 1. reset state
    repeat (3) tick();
    expect_all("reset", 8'h00, 1'b1, 1'b0, 32'd0);
    drain();
    reset_n = 1'b1;
    repeat (2) tick();
    expect_all("idle", 8'h00, 1'b1, 1'b0, 32'd0);
    drain();

    // 2. basic command 0x5A, NMI held >= 16 cycles
    wr_start(8'h5A);
    tick();
    expect_all("t2.accept", 8'h5A, 1'b0, 1'b1, 32'd0);
    drain();
    for (int i = 1; i < 27; i++) begin
      if (i == 4) wr_stop();
      tick();
      if (i == 15) begin
        expect_o("t2.nmi_held16", SEL_NMI, 32'd0);
        drain();
      end
    end
    rd_start();
    repeat (3) tick();
    expect_o("t2.dout_during_rd", SEL_DOUT, 32'h5A);
    expect_o("t2.pend_during_rd", SEL_PEND, 32'd1);
    expect_o("t2.nmi_during_rd", SEL_NMI, 32'd0);
    drain();
    rd_stop();
    tick();
    expect_all("t2.read_end", 8'h5A, 1'b1, 1'b0, 32'd0);
    drain();

    // 3. overwrite before read counts one overrun
    wr_start(8'h11); tick(); wr_stop(); tick();
    wr_start(8'h22); tick(); wr_stop(); tick();
    expect_all("t3.overwrite", 8'h22, 1'b0, 1'b1, 32'd1);
    drain();
    z80_read();
    expect_o("t3.pend_cleared", SEL_PEND, 32'd0);
    expect_o("t3.ovr_kept", SEL_OVR, 32'd1);
    drain();
    wait_nmi_high(40, n);
    expect_o("t3.nmi_release", SEL_NMI, 32'd1);
    drain();

    // UDS-only write ignored; read while empty has no side effect
    bus.m68k_latch_cs = 1'b1;
    bus.m68k_rw       = 1'b0;
    bus.m68k_lds_n    = 1'b1;
    bus.m68k_din      = 8'h99;
    repeat (3) tick();
    wr_stop();
    tick();
    expect_all("uds_only", 8'h22, 1'b1, 1'b0, 32'd1);
    drain();
    z80_read();
    expect_all("rd_empty", 8'h22, 1'b1, 1'b0, 32'd1);
    drain();

    // 4. write request held 50 cycles -> single accept
    wr_start(8'h77);
    tick();
    bus.m68k_din = 8'h88;
    repeat (49) tick();
    wr_stop();
    tick();
    expect_all("t4.held", 8'h77, 1'b0, 1'b1, 32'd1);
    drain();
    z80_read();
    expect_all("t4.read_end", 8'h77, 1'b1, 1'b0, 32'd1);
    drain();

    // 5. accept and read-end in the same cycle: write wins, no overrun
    wr_start(8'h44); tick(); wr_stop(); tick();
    rd_start(); tick(); tick();
    rd_stop();
    wr_start(8'h33);
    tick();
    expect_all("t5.same_cycle", 8'h33, 1'b0, 1'b1, 32'd1);
    drain();
    wr_stop();
    tick();
    z80_read();
    wait_nmi_high(40, n);
    expect_all("t5.drained", 8'h33, 1'b1, 1'b0, 32'd1);
    drain();

    // 6. early read-end: NMI stays low until the stretch counter expires
    wr_start(8'h5C);
    rd_start();
    tick();
    expect_all("t6.accept", 8'h5C, 1'b0, 1'b1, 32'd1);
    drain();
    tick();
    wr_stop();
    rd_stop();
    tick();
    expect_o("t6.pend_early_clear", SEL_PEND, 32'd0);
    expect_o("t6.nmi_still_low", SEL_NMI, 32'd0);
    drain();
    wait_nmi_high(40, n);
    check_eq("t6.nmi_stretch_ticks", 32'(n), 32'd14);

    // reset in the middle of an NMI pulse
    wr_start(8'h6D); tick(); wr_stop();
    repeat (3) tick();
    expect_o("t6.pre_reset_nmi", SEL_NMI, 32'd0);
    drain();
    #2;
    reset_n = 1'b0;
    #1;
    expect_all("t6.async_reset", 8'h00, 1'b1, 1'b0, 32'd0);
    drain();
    tick();
    reset_n = 1'b1;
    tick();

    // overrun counter saturates at all-ones
    for (int i = 0; i < int'(OVR_MAX) + 1; i++) begin
      wr_start(8'(i)); tick(); wr_stop(); tick();
    end
    expect_o("sat.reach", SEL_OVR, 32'(OVR_MAX));
    expect_o("sat.pending", SEL_PEND, 32'd1);
    drain();
    wr_start(8'hA5); tick(); wr_stop(); tick();
    expect_o("sat.hold", SEL_OVR, 32'(OVR_MAX));
    expect_o("sat.dout", SEL_DOUT, 32'hA5);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_sound_latch_ctrl
